input_loader: RTL and testbench
===============================

// Module: input_loader
// PURPOSE
//  Writer side of the pixel/weight buffers that layer_one reads.
//  - Accepts a byte stream from the top-level pins while the top FSM is in s_LOAD.
//  - Assembles the 784-bit image vector and the 72-bit layer-1 weight vector in the
//    flattened layouts layer_one consumes.
//  - Raises load_done so the top FSM can advance to s_LAYER_1.
// PARAMETERS
//  N_PIX   784  image bits, flattened pixels[r*28+c]
//  N_WT    72   weight bits, flattened weights[r*24+c*8+w]
//  BYTE_W  8    stream byte width; N_PIX and N_WT must be multiples of BYTE_W
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  state       in   3      top-level FSM state (s_IDLE=000, s_LOAD=001)
//  data_in     in   8      stream byte
//  data_valid  in   1      data_in valid this cycle
//  data_ready  out  1      loader accepting bytes this cycle
//  pixels      out  784    assembled image, to layer_one
//  weights     out  72     assembled weights, to layer_one
//  load_done   out  1      full image + weights captured
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - FSM=L_IDLE, byte_cnt=0, data_ready=0, load_done=0, pixels=0, weights=0.
//  - Stream order:
//    - Bytes 0..97 are pixel bytes, 98..106 are weight bytes.
//    - Pixel byte k, bit i -> pixels[8k+i].
//    - Weight byte j, bit i -> weights[8j+i].
//    - Within each byte, bit 0 is the lowest index.
//  - byte_cnt: 7 bits, 0..106; never wraps.
//  - FSM states: L_IDLE, L_PIX, L_WT, L_DONE.
//  - L_IDLE:
//    - -> L_PIX when state==s_LOAD; byte_cnt=0.
//    - data_ready=0.
//  - L_PIX:
//    - data_ready = (state==s_LOAD).
//    - A byte is accepted on an edge where data_valid && data_ready.
//    - On accept: store the byte, byte_cnt+1.
//    - Accepting byte 97 -> L_WT.
//  - L_WT:
//    - Same handshake as L_PIX.
//    - Accepting byte 106 -> L_DONE, and load_done=1 from the same edge.
//  - L_DONE:
//    - data_ready=0; data_valid ignored; load_done held at 1.
//    - -> L_IDLE when state==s_IDLE; load_done cleared on that edge.
//  - Latency:
//    - Each byte is visible on pixels/weights the cycle after its accept edge.
//    - load_done rises together with the last weight byte becoming visible.
//  - Throughput: one byte per cycle; data_valid gaps stall with no loss.
//  - Boundary conditions:
//    - state leaves s_LOAD (not to s_IDLE) mid-stream: pause. data_ready=0; byte_cnt,
//      FSM and data held; resume at the same byte on return to s_LOAD.
//    - state==s_IDLE in L_PIX or L_WT: abort to L_IDLE, byte_cnt=0. pixels/weights keep
//      their partial contents until overwritten by the next load.
//    - data_valid with data_ready=0: byte dropped, no side effect.
//    - rst_n low mid-stream: immediate full clear as above; the next load restarts
//      at byte 0.
//  - pixels/weights are registered and stable outside accept edges; layer_one may
//    read them freely once load_done=1.
// TESTING
//  - Reset: assert rst_n=0 asynchronously mid-cycle -> pixels=0, weights=0,
//    load_done=0, data_ready=0 immediately.
//  - Full load: state=001, 107 back-to-back bytes; pixel byte k=k[7:0], weight bytes
//    all 0xA5.
//    -> pixels[7:0]=0x00, pixels[15:8]=0x01, pixels[783:776]=0x61.
//    -> weights=72'hA5A5A5A5A5A5A5A5A5.
//    -> load_done=1 in the cycle after the 107th accept.
//  - Gapped valid: data_valid toggles 1,0,1,0 -> same final vectors as back-to-back;
//    load_done after exactly 107 accepted bytes.
//  - Pause: after 50 bytes set state=010 for 5 cycles with data_valid=1 ->
//    data_ready=0 and byte_cnt stays 50; return to 001 and finish -> correct
//    vectors.
//  - Abort/restart: state=000 after 30 bytes -> FSM L_IDLE.
//    -> A new 107-byte load with all 0xFF gives pixels all ones and weights all
//       ones.
//  - Done hold: after load_done, send 3 more valid bytes in s_LOAD -> ignored,
//    vectors unchanged. Then state=000 -> load_done=0 next cycle.

Source files
------------

// File: rtl/input_loader_if.sv
// rtl/input_loader_if.sv - byte stream handshake between the pin driver and input_loader
interface input_loader_if #(
    parameter int BYTE_W = 8
);
    logic [BYTE_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/input_loader.sv
// rtl/input_loader.sv - assembles the image and layer-1 weight vectors from a byte stream
module input_loader #(
    parameter int N_PIX  = 784,
    parameter int N_WT   = 72,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        state,
    input_loader_if.slave     stream,
    output logic [N_PIX-1:0]  pixels,
    output logic [N_WT-1:0]   weights,
    output logic              load_done
);
    localparam int PIX_BYTES = N_PIX / BYTE_W;
    localparam int WT_BYTES  = N_WT / BYTE_W;
    localparam int TOT_BYTES = PIX_BYTES + WT_BYTES;
    localparam int CNT_W     = $clog2(TOT_BYTES);

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_LOAD = 3'b001;

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_WT  = CNT_W'(TOT_BYTES - 1);
    localparam logic [CNT_W-1:0] WT_BASE  = CNT_W'(PIX_BYTES);

    typedef enum logic [1:0] {
        L_IDLE,
        L_PIX,
        L_WT,
        L_DONE
    } lstate_t;

    lstate_t          fsm_q;
    lstate_t          fsm_d;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             ready;
    logic             pix_wr;
    logic             wt_wr;
    logic [CNT_W-1:0] wt_idx;

    assign stream.data_ready = ready;
    assign load_done         = (fsm_q == L_DONE);
    assign wt_idx            = byte_cnt - WT_BASE;

    // FSM state and byte counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= L_IDLE;
            byte_cnt <= '0;
        end else begin
            fsm_q    <= fsm_d;
            byte_cnt <= cnt_d;
        end
    end

    // Next-state, handshake and write-enable decode; a non-LOAD, non-IDLE
    // top state simply drops ready so the stream pauses with everything held
    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = byte_cnt;
        ready  = 1'b0;
        pix_wr = 1'b0;
        wt_wr  = 1'b0;
        case (fsm_q)
            L_IDLE: begin
                if (state == S_LOAD) begin
                    fsm_d = L_PIX;
                    cnt_d = '0;
                end
            end
            L_PIX: begin
                if (state == S_IDLE) begin
                    fsm_d = L_IDLE;
                    cnt_d = '0;
                end else begin
                    ready = (state == S_LOAD);
                    if (ready && stream.data_valid) begin
                        pix_wr = 1'b1;
                        cnt_d  = byte_cnt + CNT_W'(1);
                        if (byte_cnt == LAST_PIX) begin
                            fsm_d = L_WT;
                        end
                    end
                end
            end
            L_WT: begin
                if (state == S_IDLE) begin
                    fsm_d = L_IDLE;
                    cnt_d = '0;
                end else begin
                    ready = (state == S_LOAD);
                    if (ready && stream.data_valid) begin
                        wt_wr = 1'b1;
                        // counter parks on the last index instead of running past it
                        if (byte_cnt == LAST_WT) begin
                            fsm_d = L_DONE;
                        end else begin
                            cnt_d = byte_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            L_DONE: begin
                if (state == S_IDLE) begin
                    fsm_d = L_IDLE;
                end
            end
            default: begin
                fsm_d = L_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // Pixel buffer: accepted byte lands in the slot selected by byte_cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixels <= '0;
        end else if (pix_wr) begin
            for (int k = 0; k < PIX_BYTES; k++) begin
                if (byte_cnt == CNT_W'(k)) begin
                    pixels[k*BYTE_W +: BYTE_W] <= stream.data_in;
                end
            end
        end
    end

    // Weight buffer: slot is byte_cnt relative to the first weight byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weights <= '0;
        end else if (wt_wr) begin
            for (int j = 0; j < WT_BYTES; j++) begin
                if (wt_idx == CNT_W'(j)) begin
                    weights[j*BYTE_W +: BYTE_W] <= stream.data_in;
                end
            end
        end
    end
endmodule

// File: tb/tb_input_loader.sv
// tb/tb_input_loader.sv - scoreboard bench for input_loader
module tb_input_loader;
    localparam int N_BYTES     = 107;
    localparam int N_PIX_BYTES = 98;
    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_LOAD  = 3'b001;
    localparam logic [2:0] S_OTHER = 3'b010;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [2:0]   state;
    logic [783:0] pixels;
    logic [71:0]  weights;
    logic         load_done;

    input_loader_if bus ();

    input_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .stream    (bus),
        .pixels    (pixels),
        .weights   (weights),
        .load_done (load_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: phase 0 idle, 1 loading, 2 done
    logic [783:0] m_pix = '0;
    logic [71:0]  m_wt = '0;
    int           m_phase = 0;
    int           m_cnt = 0;
    logic         m_done = 1'b0;
    logic [7:0]   src [N_BYTES];

    typedef struct {
        logic [783:0] pix;
        logic [71:0]  wt;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [783:0] act, input logic [783:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: load_done timing every cycle; vectors popped from the scoreboard on its rise
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("load_done", {783'd0, load_done}, {783'd0, m_done});
            if (load_done && !prev_done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 784'd1, 784'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_pixels", pixels, e.pix);
                    chk("sb_weights", {712'd0, weights}, {712'd0, e.wt});
                end
            end
            prev_done = load_done;
        end
    end

    task automatic step(input logic [2:0] st, input logic v, input logic [7:0] d);
        logic exp_ready;
        @(negedge clk);
        state = st;
        bus.data_valid = v;
        bus.data_in = d;
        #1;
        exp_ready = (m_phase == 1) && (st == S_LOAD);
        chk("data_ready", {783'd0, bus.data_ready}, {783'd0, exp_ready});
        @(posedge clk);
        case (m_phase)
            0: if (st == S_LOAD) begin m_phase = 1; m_cnt = 0; end
            1: begin
                if (st == S_IDLE) begin
                    m_phase = 0;
                    m_cnt = 0;
                end else if (exp_ready && v) begin
                    if (m_cnt < N_PIX_BYTES) m_pix[m_cnt*8 +: 8] = d;
                    else m_wt[(m_cnt-N_PIX_BYTES)*8 +: 8] = d;
                    m_cnt++;
                    if (m_cnt == N_BYTES) begin
                        m_phase = 2;
                        sb_q.push_back('{m_pix, m_wt});
                    end
                end
            end
            default: if (st == S_IDLE) m_phase = 0;
        endcase
        m_done = (m_phase == 2);
    endtask

    // gap: 0 back-to-back, 1 alternating, 2 random
    task automatic send_range(input int hi, input int gap);
        int   budget;
        logic v;
        logic tog;
        budget = 3000;
        tog = 1'b1;
        while (m_phase != 2 && !(m_phase == 1 && m_cnt >= hi)) begin
            if (budget == 0) begin
                chk("stream_timeout", 784'd1, 784'd0);
                return;
            end
            budget--;
            if (gap == 0) v = 1'b1;
            else if (gap == 1) begin v = tog; tog = ~tog; end
            else v = ($urandom_range(0, 3) != 0);
            step(S_LOAD, v, v ? src[m_cnt] : 8'($urandom));
        end
    endtask

    task automatic go_idle();
        step(S_IDLE, 1'b0, 8'h00);
        step(S_IDLE, 1'b0, 8'h00);
    endtask

    task automatic fill_spec();
        for (int k = 0; k < N_BYTES; k++) src[k] = (k < N_PIX_BYTES) ? 8'(k) : 8'hA5;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < N_BYTES; k++) src[k] = 8'($urandom);
    endtask

    task automatic async_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_pixels", pixels, 784'd0);
        chk("rst_weights", {712'd0, weights}, 784'd0);
        chk("rst_load_done", {783'd0, load_done}, 784'd0);
        chk("rst_data_ready", {783'd0, bus.data_ready}, 784'd0);
        m_pix = '0; m_wt = '0; m_phase = 0; m_cnt = 0; m_done = 1'b0;
        prev_done = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        state = S_IDLE;
        bus.data_valid = 1'b0;
        bus.data_in = 8'h00;
        #2;
        async_reset();

        // full load with the documented pattern
        fill_spec();
        send_range(N_BYTES, 0);
        #2;
        chk("pix_byte0", {776'd0, pixels[7:0]}, 784'h00);
        chk("pix_byte1", {776'd0, pixels[15:8]}, 784'h01);
        chk("pix_byte97", {776'd0, pixels[783:776]}, 784'h61);
        chk("wt_all_a5", {712'd0, weights}, {712'd0, 72'hA5A5A5A5A5A5A5A5A5});

        // done hold: extra bytes ignored
        for (int i = 0; i < 3; i++) step(S_LOAD, 1'b1, 8'h3C);
        #2;
        chk("hold_pixels", pixels, m_pix);
        chk("hold_weights", {712'd0, weights}, {712'd0, m_wt});
        go_idle();

        // gapped valid, same data
        send_range(N_BYTES, 1);
        go_idle();

        // pause after 50 bytes
        fill_rand();
        send_range(50, 0);
        for (int i = 0; i < 5; i++) step(S_OTHER, 1'b1, 8'($urandom));
        send_range(N_BYTES, 0);
        go_idle();

        // abort after 30 bytes, then an all-ones load
        fill_rand();
        send_range(30, 0);
        step(S_IDLE, 1'b1, 8'hEE);
        step(S_IDLE, 1'b1, 8'hEE);
        for (int k = 0; k < N_BYTES; k++) src[k] = 8'hFF;
        send_range(N_BYTES, 2);
        #2;
        chk("ones_pixels", pixels, {784{1'b1}});
        chk("ones_weights", {712'd0, weights}, {712'd0, {72{1'b1}}});
        go_idle();

        // random loads with random gaps and a random pause point
        for (int n = 0; n < 3; n++) begin
            int p;
            fill_rand();
            p = $urandom_range(1, N_BYTES - 1);
            send_range(p, 2);
            for (int i = 0; i < 3; i++) step(S_OTHER, 1'b1, 8'($urandom));
            send_range(N_BYTES, 2);
            go_idle();
        end

        // async reset mid-stream, then a clean load from byte 0
        fill_rand();
        send_range(40, 0);
        async_reset();
        fill_rand();
        send_range(N_BYTES, 2);
        go_idle();

        chk("sb_drained", 784'(sb_q.size()), 784'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
